// File: rtl/max_pkg.sv
// max_pkg: shared state encoding and default sizing for the sequential max controller.
package max_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

    localparam int W_DEF  = 4;
    localparam int N_DEF  = 8;
    localparam int IW_DEF = $clog2(N_DEF);

endpackage

// File: rtl/max_cmp_sel.sv
// max_cmp_sel: unsigned W-bit compare/select slice; ties select b.
module max_cmp_sel #(
    parameter int W = max_pkg::W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic [W-1:0] sel_max
);

    assign gt      = a > b;
    assign sel_max = gt ? a : b;

endmodule

// File: rtl/max_seq_ctrl.sv
// max_seq_ctrl: streams words through one compare/select slice, reporting frame max, index, count.
module max_seq_ctrl
    import max_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int N  = N_DEF,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_max,
    output logic [IW-1:0] out_idx,
    output logic [IW:0]   out_count,
    output logic          out_trunc
);

    state_e        state_q, state_d;
    logic [W-1:0]  max_q, max_d, cmp_b, sel_max;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW:0]   cnt_q, cnt_d, cnt_inc;
    logic          trunc_q, trunc_d, gt, accept, full, first;

    assign first     = state_q == IDLE;
    assign in_ready  = !rst && state_q != HOLD;
    assign out_valid = state_q == HOLD;
    assign accept    = in_valid && in_ready;
    // Comparing the first word against zero always selects it, so one slice covers both load and update.
    assign cmp_b     = first ? '0 : max_q;
    assign cnt_inc   = first ? (IW+1)'(1) : cnt_q + (IW+1)'(1);
    assign full      = cnt_inc == (IW+1)'(N);

    max_cmp_sel #(.W(W)) u_cmp (
        .a       (in_data),
        .b       (cmp_b),
        .gt      (gt),
        .sel_max (sel_max)
    );

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        trunc_d = trunc_q;
        if (accept) begin
            max_d   = sel_max;
            idx_d   = first ? '0 : (gt ? cnt_q[IW-1:0] : idx_q);
            cnt_d   = cnt_inc;
            trunc_d = full && !in_last;
            state_d = (in_last || full) ? HOLD : ACCUM;
        end else if (out_valid && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            max_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    assign out_max   = max_q;
    assign out_idx   = idx_q;
    assign out_count = cnt_q;
    assign out_trunc = trunc_q;

endmodule

// File: tb/tb_max_seq_ctrl.sv
// tb_max_seq_ctrl: directed and random frames checked against a frame-level max/position model.
module tb_max_seq_ctrl;

    localparam int W  = 4;
    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, out_valid, out_trunc;
    logic [W-1:0]  out_max;
    logic [IW-1:0] out_idx;
    logic [IW:0]   out_count;

    int total = 0, bad = 0;
    int frame_q[$];

    max_seq_ctrl #(.W(W), .N(N), .IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_words(input bit with_last, input int gap_min, input int gap_max);
        for (int i = 0; i < frame_q.size(); i++) begin
            int g;
            g = $urandom_range(gap_max, gap_min);
            in_valid = 1'b0;
            repeat (g) tick();
            chk("in_ready_frame", 32'(in_ready), 1);
            chk("out_valid_busy", 32'(out_valid), 0);
            in_valid = 1'b1;
            in_data  = W'(frame_q[i]);
            in_last  = with_last && (i == frame_q.size() - 1);
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic run_frame(input bit with_last, input int gap_min, input int gap_max, input int hold);
        int m, mi, cnt;
        bit tr;
        send_words(with_last, gap_min, gap_max);
        m = -1;
        mi = 0;
        foreach (frame_q[i]) if (frame_q[i] > m) begin m = frame_q[i]; mi = i; end
        cnt = frame_q.size();
        tr  = (cnt == N) && !with_last;
        chk("out_valid_rise", 32'(out_valid), 1);
        chk("in_ready_hold", 32'(in_ready), 0);
        chk("out_max", 32'(out_max), m);
        chk("out_idx", 32'(out_idx), mi);
        chk("out_count", 32'(out_count), cnt);
        chk("out_trunc", 32'(out_trunc), 32'(tr));
        repeat (hold) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            tick();
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_ready", 32'(in_ready), 0);
            chk("stall_max", 32'(out_max), m);
            chk("stall_idx", 32'(out_idx), mi);
            chk("stall_count", 32'(out_count), cnt);
            chk("stall_trunc", 32'(out_trunc), 32'(tr));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_clear", 32'(out_valid), 0);
        chk("in_ready_idle", 32'(in_ready), 1);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_max", 32'(out_max), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_out_trunc", 32'(out_trunc), 0);
        chk("rst_in_ready_rel", 32'(in_ready), 1);

        frame_q = '{3, 9, 2, 9};
        run_frame(1'b1, 0, 0, 0);
        frame_q = '{5};
        run_frame(1'b1, 0, 0, 0);
        frame_q = '{1, 2, 3, 4, 5, 6, 7, 8};
        run_frame(1'b0, 0, 0, 2);
        frame_q = '{1, 2, 3, 4, 5, 6, 7, 8};
        run_frame(1'b1, 0, 0, 0);
        frame_q = '{15, 15, 0};
        run_frame(1'b1, 0, 0, 5);
        frame_q = '{7, 4, 12};
        run_frame(1'b1, 2, 3, 0);

        frame_q = '{10, 11, 12};
        send_words(1'b0, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_no_valid", 32'(out_valid), 0);
            tick();
        end
        chk("midrst_count", 32'(out_count), 0);
        frame_q = '{6};
        run_frame(1'b1, 0, 0, 0);

        for (int f = 0; f < 30; f++) begin
            int len;
            bit wl;
            len = $urandom_range(N, 1);
            wl  = (len < N) ? 1'b1 : 1'($urandom_range(1, 0));
            frame_q.delete();
            for (int i = 0; i < len; i++) frame_q.push_back($urandom_range(15, 0));
            run_frame(wl, 0, $urandom_range(2, 0), $urandom_range(3, 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/max_seq_ctrl.md
# max_seq_ctrl

Sequential controller that streams W-bit unsigned words through a single compare-and-select datapath slice and reports the maximum of each frame together with its position. It sits in front of the combinational max partitions. It owns the running-max register, sequences one comparison per accepted word, and handles frame delimiting and output back-pressure. It lets one compare/select slice be shared by an arbitrary-length operand stream, instead of instantiating a wide max tree.

## Interface
Parameters:
- W, 4, operand width in bits (unsigned).
- N, 8, maximum words per frame (power of two, ≥2).
- IW, $clog2(N), index/count width.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  word present on in_data.
- in_ready  output  1  controller accepts a word this cycle.
- in_data  input  W  operand word.
- in_last  input  1  marks the final word of the frame; qualified by in_valid.
- out_valid  output  1  result valid, held until accepted.
- out_ready  input  1  downstream accepts the result.
- out_max  output  W  frame maximum.
- out_idx  output  IW  0-based position of the maximum within the frame.
- out_count  output  IW+1  number of words in the frame (1..N).
- out_trunc  output  1  frame closed by reaching N words without in_last.

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- IDLE: in_ready=1. On accept, the word loads max_r with index 0 and cnt=1.
  - If in_last is set, or N==1 is reached, go to HOLD.
  - Otherwise go to ACCUM.
- ACCUM: in_ready=1. On accept, the slice compares in_data against max_r.
  - Replace max_r/idx_r only when in_data > max_r (strict). Ties keep the earlier index.
  - cnt increments on every accept.
  - Go to HOLD when in_last is set or cnt reaches N.
- HOLD: in_ready=0. out_valid=1 and outputs are stable.
  - On out_valid&&out_ready, go to IDLE and clear out_valid.
- out_trunc=1 when the frame closed on cnt==N with in_last=0. in_last on word N gives out_trunc=0.
- in_last arriving together with cnt==N counts as one closure, not two.
- No accept occurs while in_valid=0. State and registers hold.
- Comparison is unsigned W-bit with no carry-out. Max of all-ones words is 2^W−1, and the index is the first occurrence.

## Timing
- Reset values: state=IDLE, in_ready=1 after reset release, out_valid=0, out_max=0, out_idx=0, out_count=0, out_trunc=0. During rst, in_ready=0.
- Reset mid-frame or in HOLD discards the partial or pending result. No out_valid is issued.
- Throughput: one word per cycle inside a frame.
- Latency: out_valid rises the cycle after the last word is accepted (registered).
- Inter-frame gap: a minimum of one cycle of in_ready=0, the HOLD cycle. The next frame's first word can be accepted in the cycle after the out handshake.
- in_ready depends only on state (registered), with no combinational path from out_ready.
- Outputs must not change while out_valid=1 and out_ready=0.

## Structure
- Package max_pkg holds:
  - the state enum (IDLE/ACCUM/HOLD);
  - default W/N constants;
  - the ceiling-log helper constant used for IW.
- Sub-module max_cmp_sel (combinational, W-bit) takes a, b and returns gt and sel_max. It is the shared slice; the controller instantiates it exactly once.
- Everything else (FSM, counters, result registers) stays in max_seq_ctrl.

## Test plan
- Frame {3,9,2,9} with in_last on word 4 and out_ready=1 → out_max=9, out_idx=1, out_count=4, out_trunc=0. out_valid rises the cycle after word 4.
- Single-word frame {5} with in_last → out_max=5, out_idx=0, out_count=1, one cycle later.
- N=8 words {1..8} with no in_last → closes after word 8: out_max=8, out_idx=7, out_count=8, out_trunc=1. A 9th word is not accepted until after the handshake.
- Hold out_ready=0 for 5 cycles after result {15,15,0} → out_valid and outputs stable, in_ready=0, max=15, idx=0. The handshake on cycle 6 returns to IDLE.
- Gapped in_valid (bubbles between words 7,4,12) → result max=12, idx=2, count=3, and bubbles do not advance cnt.
- Assert rst in ACCUM after 3 words → out_valid never asserts. The next frame {6} yields max=6, idx=0, count=1.
